// File: rtl/smem_fill_if.sv
// CPU-side screen-memory bus shared by the CPU path and the fill engine.
// The slave modport is the arbiter's view; master is the driver's side.
interface smem_fill_if #(
  parameter int unsigned Abits = 11,
  parameter int unsigned Dbits = 32
);
  logic             cpu_smem_sel;
  logic             cpu_smem_wr;
  logic [Abits-1:0] cpu_smem_addr;
  logic [Dbits-1:0] cpu_smem_wd;
  logic             fill_start;
  logic [Dbits-1:0] fill_value;
  logic [Abits-1:0] fill_base;
  logic [Abits:0]   fill_len;
  logic             smem_wr;
  logic [Abits-1:0] smem_addr;
  logic [Dbits-1:0] smem_wd;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output cpu_smem_sel, cpu_smem_wr, cpu_smem_addr, cpu_smem_wd,
    output fill_start, fill_value, fill_base, fill_len,
    input  smem_wr, smem_addr, smem_wd, busy, done, err
  );

  modport slave (
    input  cpu_smem_sel, cpu_smem_wr, cpu_smem_addr, cpu_smem_wd,
    input  fill_start, fill_value, fill_base, fill_len,
    output smem_wr, smem_addr, smem_wd, busy, done, err
  );
endinterface

// File: rtl/smem_fill_ctrl.sv
// Screen-memory fill engine sharing the CPU port; the CPU always wins and the
// engine writes one location per cycle the CPU leaves the port free.
module smem_fill_ctrl #(
  parameter int unsigned Nloc  = 1200,
  parameter int unsigned Abits = 11,
  parameter int unsigned Dbits = 32
) (
  input logic        clk,
  input logic        reset_n,
  smem_fill_if.slave bus
);

  localparam int unsigned LW = Abits + 1;
  localparam logic [LW-1:0] NlocW = LW'(Nloc);

  typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

  state_e           state_q, state_d;
  logic [LW-1:0]    offset_q, offset_d;
  logic [LW-1:0]    len_q, len_d;
  logic [Abits-1:0] base_q, base_d;
  logic [Dbits-1:0] value_q, value_d;
  logic             err_q, err_d;

  logic [LW-1:0]    len_clamp;
  logic [LW-1:0]    addr_sum;
  logic [Abits-1:0] fill_addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      offset_q <= '0;
      len_q    <= '0;
      base_q   <= '0;
      value_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      len_q    <= len_d;
      base_q   <= base_d;
      value_q  <= value_d;
      err_q    <= err_d;
    end
  end

  // Sum is at most 2*Nloc-2, so a single conditional subtract wraps the run.
  always_comb begin
    len_clamp = (bus.fill_len > NlocW) ? NlocW : bus.fill_len;
    addr_sum  = {1'b0, base_q} + offset_q;
    fill_addr = (addr_sum >= NlocW) ? Abits'(addr_sum - NlocW) : Abits'(addr_sum);
  end

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    len_d    = len_q;
    base_d   = base_q;
    value_d  = value_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.fill_start) begin
          value_d  = bus.fill_value;
          base_d   = bus.fill_base;
          len_d    = len_clamp;
          offset_d = '0;
          err_d    = 1'b0;
          if ({1'b0, bus.fill_base} >= NlocW) begin
            state_d = StDone;
            err_d   = 1'b1;
          end else if (len_clamp == '0) begin
            state_d = StDone;
          end else begin
            state_d = StFill;
          end
        end
      end
      StFill: begin
        if (!bus.cpu_smem_sel) begin
          offset_d = offset_q + LW'(1);
          if (offset_q == len_q - LW'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    bus.smem_addr = bus.cpu_smem_addr;
    bus.smem_wd   = bus.cpu_smem_wd;
    bus.smem_wr   = bus.cpu_smem_wr;
    if (!bus.cpu_smem_sel && (state_q == StFill)) begin
      bus.smem_addr = fill_addr;
      bus.smem_wd   = value_q;
      bus.smem_wr   = 1'b1;
    end
    bus.busy = (state_q == StFill);
    bus.done = (state_q == StDone);
    bus.err  = err_q;
  end

endmodule

// File: tb/tb_smem_fill_ctrl.sv
// Scoreboard bench for smem_fill_ctrl: stimulus queues expected fill writes and
// done pulses; a negedge monitor pops and compares whatever the DUT presents.
module tb_smem_fill_ctrl;

  typedef struct packed {
    logic [10:0] addr;
    logic [31:0] wd;
  } wr_t;

  logic clk;
  logic reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  wr_t  exp_wr[$];
  logic exp_done[$];

  smem_fill_if #(.Abits(11), .Dbits(32)) bus ();

  smem_fill_ctrl #(.Nloc(1200), .Abits(11), .Dbits(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: fill writes are the writes seen while the CPU is off the port.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.cpu_smem_sel) begin
        check("cpu_addr", 32'(bus.smem_addr), 32'(bus.cpu_smem_addr));
        check("cpu_wd", bus.smem_wd, bus.cpu_smem_wd);
        check("cpu_wr", 32'(bus.smem_wr), 32'(bus.cpu_smem_wr));
      end else if (bus.smem_wr) begin
        if (exp_wr.size() == 0) begin
          flag($sformatf("unexpected_write addr=%0d wd=%0h", bus.smem_addr, bus.smem_wd));
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          check("fill_addr", 32'(bus.smem_addr), 32'(e.addr));
          check("fill_wd", bus.smem_wd, e.wd);
        end
      end
      if (bus.done) begin
        if (exp_done.size() == 0) begin
          flag("unexpected_done");
        end else begin
          logic e_err;
          e_err = exp_done.pop_front();
          check("done_err", 32'(bus.err), 32'(e_err));
        end
      end
    end
  end

  task automatic push_wr(input int addr, input logic [31:0] wd);
    wr_t e;
    e.addr = 11'(addr);
    e.wd   = wd;
    exp_wr.push_back(e);
  endtask

  task automatic push_run(input int base, input int n, input logic [31:0] wd);
    for (int i = 0; i < n; i++) begin
      push_wr((base + i) % 1200, wd);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the accepting edge, i.e. in cycle 1.
  task automatic start_fill(input int base, input int len, input logic [31:0] val);
    bus.fill_base  = 11'(base);
    bus.fill_len   = 12'(len);
    bus.fill_value = val;
    bus.fill_start = 1'b1;
    step();
    bus.fill_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int k0, input int exp_cycle);
    int k;
    k = k0;
    while (!bus.done && k < exp_cycle + 20) begin
      step();
      k++;
    end
    if (!bus.done) flag({name, "_done_timeout"});
    else check({name, "_done_cycle"}, 32'(k), 32'(exp_cycle));
    check({name, "_busy_at_done"}, 32'(bus.busy), 0);
    step();
    check({name, "_done_one_cycle"}, 32'(bus.done), 0);
  endtask

  task automatic run_fill(input string name, input int base, input int len,
                          input logic [31:0] val, input int exp_cycle, input logic exp_err);
    exp_done.push_back(exp_err);
    start_fill(base, len, val);
    if (exp_cycle > 1) check({name, "_busy"}, 32'(bus.busy), 1);
    wait_done(name, 1, exp_cycle);
    check({name, "_err"}, 32'(bus.err), 32'(exp_err));
    check({name, "_writes_left"}, 32'(exp_wr.size()), 0);
  endtask

  initial begin
    reset_n           = 1'b1;
    bus.cpu_smem_sel  = 1'b0;
    bus.cpu_smem_wr   = 1'b0;
    bus.cpu_smem_addr = '0;
    bus.cpu_smem_wd   = '0;
    bus.fill_start    = 1'b0;
    bus.fill_value    = '0;
    bus.fill_base     = '0;
    bus.fill_len      = '0;

    // Reset with no clock edge yet.
    #1 reset_n = 1'b0;
    bus.cpu_smem_wr = 1'b1;
    #1;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_err", 32'(bus.err), 0);
    check("rst_wr_pass1", 32'(bus.smem_wr), 1);
    bus.cpu_smem_wr = 1'b0;
    #1;
    check("rst_wr_pass0", 32'(bus.smem_wr), 0);
    #1 reset_n = 1'b1;
    step();

    // Basic run: 0..3, done in cycle 5.
    push_run(0, 4, 32'h2);
    run_fill("basic", 0, 4, 32'h2, 5, 1'b0);

    // Wrap past the last location.
    push_wr(1198, 32'h7);
    push_wr(1199, 32'h7);
    push_wr(0, 32'h7);
    push_wr(1, 32'h7);
    run_fill("wrap", 1198, 4, 32'h7, 5, 1'b0);

    // Same fill with the CPU grabbing the port for two cycles.
    push_wr(1198, 32'h7);
    push_wr(1199, 32'h7);
    push_wr(0, 32'h7);
    push_wr(1, 32'h7);
    exp_done.push_back(1'b0);
    start_fill(1198, 4, 32'h7);
    step();
    bus.cpu_smem_sel  = 1'b1;
    bus.cpu_smem_wr   = 1'b1;
    bus.cpu_smem_addr = 11'd5;
    bus.cpu_smem_wd   = 32'h9;
    step();
    check("cpu_stall_busy", 32'(bus.busy), 1);
    step();
    bus.cpu_smem_sel  = 1'b0;
    bus.cpu_smem_wr   = 1'b0;
    bus.cpu_smem_addr = '0;
    bus.cpu_smem_wd   = '0;
    wait_done("cpu_prio", 4, 7);
    check("cpu_prio_writes_left", 32'(exp_wr.size()), 0);

    // Zero length: no writes, done the cycle after start.
    run_fill("len0", 37, 0, 32'h1, 1, 1'b0);

    // Over-long run clamps to every location exactly once.
    push_run(100, 1200, 32'h55);
    run_fill("len2000", 100, 2000, 32'h55, 1201, 1'b0);

    // Out-of-range base: abort with sticky err.
    run_fill("base1200", 1200, 4, 32'h1, 1, 1'b1);
    repeat (3) step();
    check("err_sticky", 32'(bus.err), 1);

    // Second start mid-fill is ignored.
    push_run(10, 6, 32'h3);
    exp_done.push_back(1'b0);
    start_fill(10, 6, 32'h3);
    check("restart_err_clear", 32'(bus.err), 0);
    step();
    bus.fill_base  = 11'd500;
    bus.fill_len   = 12'd2;
    bus.fill_value = 32'hF;
    bus.fill_start = 1'b1;
    step();
    bus.fill_start = 1'b0;
    wait_done("busy_start", 3, 7);
    check("busy_start_writes_left", 32'(exp_wr.size()), 0);

    // Reset after the third write of a ten-location fill.
    push_run(20, 3, 32'h5);
    start_fill(20, 10, 32'h5);
    step();
    step();
    step();
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_done", 32'(bus.done), 0);
    check("mid_rst_writes_left", 32'(exp_wr.size()), 0);
    step();
    step();
    reset_n = 1'b1;
    step();
    check("post_rst_busy", 32'(bus.busy), 0);
    check("post_rst_done", 32'(bus.done), 0);
    push_run(0, 3, 32'hA);
    run_fill("post_rst", 0, 3, 32'hA, 4, 1'b0);

    repeat (3) step();
    check("final_writes_left", 32'(exp_wr.size()), 0);
    check("final_done_left", 32'(exp_done.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
